// File: rtl/instruction_sequencer_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
//   seq_state_t : sequencer FSM states (IDLE, ISSUE, HOLD, DONE)
//   INSTR_W     : instruction word width
//   DLY/DST/SRC : decoder field boundaries inside an instruction word
//   hold_len()  : cycles a word is held after issue, max(delay+1, min_hold)
package seq_pkg;

    localparam int INSTR_W = 9;

    localparam int DLY_HI = 8;
    localparam int DLY_LO = 6;
    localparam int DST_HI = 5;
    localparam int DST_LO = 3;
    localparam int SRC_HI = 2;
    localparam int SRC_LO = 0;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        HOLD,
        DONE
    } seq_state_t;

    function automatic logic [3:0] hold_len(input logic [2:0] dly,
                                            input logic [3:0] min_hold);
        logic [3:0] h;
        h = {1'b0, dly} + 4'd1;
        return (h < min_hold) ? min_hold : h;
    endfunction

endpackage

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if: program-load, control and decoder-facing
// signals of the instruction sequencer.
//   master : drives wr_en/wr_addr/wr_data/prog_len/start/stop,
//            observes instruct/instr_valid/pc/busy/done/wr_err
//   slave  : the sequencer side (directions reversed)
interface instruction_sequencer_if #(
    parameter int DEPTH = 8
);
    import seq_pkg::*;

    localparam int AW = $clog2(DEPTH);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [INSTR_W-1:0] wr_data;
    logic [AW:0]        prog_len;
    logic               start;
    logic               stop;
    logic [INSTR_W-1:0] instruct;
    logic               instr_valid;
    logic [AW-1:0]      pc;
    logic               busy;
    logic               done;
    logic               wr_err;

    modport master (
        output wr_en, wr_addr, wr_data, prog_len, start, stop,
        input  instruct, instr_valid, pc, busy, done, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, prog_len, start, stop,
        output instruct, instr_valid, pc, busy, done, wr_err
    );

endinterface

// File: rtl/instruction_sequencer_hold_counter.sv
// seq_hold_counter: per-word hold timer.
//   clk, reset : clock, synchronous active-high reset
//   load       : load max(delay+1, MIN_HOLD) (issued word's delay field)
//   delay      : delay field of the word being issued
//   expire     : high in the last hold cycle (count == 1)
module seq_hold_counter
    import seq_pkg::*;
#(
    parameter int MIN_HOLD = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [2:0] delay,
    output logic       expire
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= hold_len(delay, 4'(MIN_HOLD));
        end else if (count != '0) begin
            count <= count - 4'd1;
        end
    end

    assign expire = !load && (count == 4'd1);

endmodule

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: stores a short program of decoder words and issues
// them in order, holding each for max(delay+1, MIN_HOLD) cycles.
//   clk, reset : clock, synchronous active-high reset
//   bus        : instruction_sequencer_if.slave (program writes, start/stop,
//                instruct/instr_valid/pc/busy/done/wr_err)
// Build option: define SEQ_LOOP_EN to restart at word 0 after the last word
// instead of finishing through DONE.
module instruction_sequencer
    import seq_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AW       = $clog2(DEPTH),
    parameter int MIN_HOLD = 3
) (
    input logic                     clk,
    input logic                     reset,
    instruction_sequencer_if.slave  bus
);

    seq_state_t         state_q, state_d;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] cur_word;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [AW-1:0]      pc_q, pc_d;
    logic [AW:0]        len_q, len_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;
    logic               wr_err_q;
    logic               busy;
    logic               hold_load;
    logic               hold_expire;
    logic               last_word;

    assign busy      = (state_q == ISSUE) || (state_q == HOLD);
    assign cur_word  = mem[pc_q];
    assign last_word = ({1'b0, pc_q} == (len_q - (AW+1)'(1)));

    // Program memory: writes only while not executing, no reset.
    always_ff @(posedge clk) begin
        if (bus.wr_en && !busy) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    seq_hold_counter #(
        .MIN_HOLD (MIN_HOLD)
    ) u_hold (
        .clk    (clk),
        .reset  (reset),
        .load   (hold_load),
        .delay  (cur_word[DLY_HI:DLY_LO]),
        .expire (hold_expire)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        len_d     = len_q;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        hold_load = 1'b0;
        if (bus.stop) begin
            state_d = IDLE;
            instr_d = '0;
            pc_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.prog_len == '0) begin
                            state_d = DONE;
                        end else begin
                            len_d   = (bus.prog_len > (AW+1)'(DEPTH)) ?
                                      (AW+1)'(DEPTH) : bus.prog_len;
                            pc_d    = '0;
                            state_d = ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    instr_d   = cur_word;
                    valid_d   = 1'b1;
                    hold_load = 1'b1;
                    state_d   = HOLD;
                end
                HOLD: begin
                    if (hold_expire) begin
                        if (last_word) begin
`ifdef SEQ_LOOP_EN
                            pc_d    = '0;
                            state_d = ISSUE;
`else
                            state_d = DONE;
`endif
                        end else begin
                            pc_d    = pc_q + AW'(1);
                            state_d = ISSUE;
                        end
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            pc_q     <= '0;
            len_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            wr_err_q <= bus.wr_en && busy;
        end
    end

    assign bus.instruct    = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy;
    assign bus.done        = done_q;
    assign bus.wr_err      = wr_err_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer: directed and randomized runs of
// instruction_sequencer checked against a timeline model derived from the
// issue/hold rules (word i appears at 1 + sum of earlier (1+hold) cycles).
module tb_instruction_sequencer;
    import seq_pkg::*;

    localparam int DEPTH    = 8;
    localparam int AW       = $clog2(DEPTH);
    localparam int MIN_HOLD = 3;
`ifdef SEQ_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    typedef struct packed {
        logic [8:0]    instr;
        logic          valid;
        logic [AW-1:0] pc;
        logic          busy;
        logic          done;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instruction_sequencer_if #(.DEPTH(DEPTH)) bus ();

    instruction_sequencer #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .MIN_HOLD (MIN_HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            n_total = 0;
    int            n_bad   = 0;
    logic [8:0]    ref_mem [DEPTH];
    logic [8:0]    cur_w   [DEPTH];
    int            cur_len;
    logic [8:0]    prev_instr;
    logic [AW-1:0] prev_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int hold_of(input logic [8:0] w);
        int h;
        h = int'(w[8:6]) + 1;
        if (h < MIN_HOLD) h = MIN_HOLD;
        return h;
    endfunction

    function automatic int clamp_len(input int plen);
        return (plen > DEPTH) ? DEPTH : plen;
    endfunction

    // Observation index of the done pulse, counted from the start edge.
    function automatic int prog_cycles(input int plen);
        int s;
        s = 1;
        for (int i = 0; i < clamp_len(plen); i++) s += 1 + hold_of(ref_mem[i]);
        return s;
    endfunction

    // Expected outputs k cycles after the start edge.
    function automatic exp_t model_at(input int k);
        exp_t e;
        int t, n, idx, p;
        bit last;
        e = '{instr: prev_instr, valid: 1'b0, pc: prev_pc, busy: 1'b0, done: 1'b0};
        if (cur_len == 0) begin
            e.done = (k == 1);
            return e;
        end
        if (k == 0) begin
            e.pc   = '0;
            e.busy = 1'b1;
            return e;
        end
        t = 1;
        n = 0;
        while (1) begin
            idx  = n % cur_len;
            p    = 1 + hold_of(cur_w[idx]);
            last = (idx == cur_len - 1);
            if (k < t + p) begin
                e.instr = cur_w[idx];
                e.valid = (k == t);
                e.busy  = 1'b1;
                e.pc    = AW'(idx);
                if (k == t + p - 1) begin
                    if (last && !LOOP) e.busy = 1'b0;
                    else               e.pc   = last ? '0 : AW'(idx + 1);
                end
                return e;
            end
            if (last && !LOOP) begin
                e.instr = cur_w[idx];
                e.pc    = AW'(idx);
                e.done  = (k == t + p);
                return e;
            end
            t += p;
            n++;
        end
        return e;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_instruct"}, 32'(bus.instruct), 0);
        check({tag, "_valid"},    32'(bus.instr_valid), 0);
        check({tag, "_pc"},       32'(bus.pc), 0);
        check({tag, "_busy"},     32'(bus.busy), 0);
        check({tag, "_done"},     32'(bus.done), 0);
        check({tag, "_wr_err"},   32'(bus.wr_err), 0);
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [8:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        step();
        bus.wr_en = 1'b0;
        check("wr_err_idle", 32'(bus.wr_err), 0);
        ref_mem[a] = d;
    endtask

    // One program run; the *_at arguments are observation indices (-1: none)
    // after which stop / reset / a write / a stray start are driven.
    task automatic run_prog(input int plen, input int stop_at, input int rst_at,
                            input int wr_at, input logic [AW-1:0] wa,
                            input logic [8:0] wd, input int st_at,
                            output int done_k);
        exp_t e;
        int   limit, sa;
        bit   busy_prev, wr_now;
        cur_len = clamp_len(plen);
        for (int i = 0; i < DEPTH; i++) cur_w[i] = ref_mem[i];
        limit = (LOOP && cur_len > 0) ? 40 : prog_cycles(plen) + 1;
        sa = stop_at;
        if (LOOP && cur_len > 0 && sa < 0 && rst_at < 0) sa = limit;
        done_k        = -1;
        bus.prog_len  = (AW+1)'(plen);
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        busy_prev = 1'b0;
        wr_now    = 1'b0;
        for (int k = 0; k <= limit; k++) begin
            e = model_at(k);
            check("instruct",    32'(bus.instruct),    32'(e.instr));
            check("instr_valid", 32'(bus.instr_valid), 32'(e.valid));
            check("pc",          32'(bus.pc),          32'(e.pc));
            check("busy",        32'(bus.busy),        32'(e.busy));
            check("done",        32'(bus.done),        32'(e.done));
            check("wr_err",      32'(bus.wr_err),      32'(wr_now && busy_prev));
            if (bus.done === 1'b1 && done_k < 0) done_k = k;
            if (wr_now && !busy_prev) ref_mem[wa] = wd;
            busy_prev  = e.busy;
            wr_now     = 1'b0;
            bus.wr_en  = 1'b0;
            bus.start  = 1'b0;
            if (k == sa) begin
                bus.stop = 1'b1;
                step();
                bus.stop = 1'b0;
                check_zero("stop");
                step();
                check("stop_no_done", 32'(bus.done), 0);
                prev_instr = '0;
                prev_pc    = '0;
                return;
            end
            if (k == rst_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                check_zero("rst");
                prev_instr = '0;
                prev_pc    = '0;
                return;
            end
            if (k == wr_at) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = wa;
                bus.wr_data = wd;
                wr_now      = 1'b1;
            end
            if (k == st_at) begin
                bus.start    = 1'b1;
                bus.prog_len = (AW+1)'($urandom_range(0, 2*DEPTH-1));
            end
            if (k < limit) step();
        end
        if (cur_len > 0) begin
            prev_instr = cur_w[cur_len-1];
            prev_pc    = AW'(cur_len - 1);
        end
    endtask

    task automatic start_stop_together();
        bus.start    = 1'b1;
        bus.stop     = 1'b1;
        bus.prog_len = (AW+1)'(3);
        step();
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        check_zero("ss");
        step();
        check("ss_busy", 32'(bus.busy), 0);
        check("ss_done", 32'(bus.done), 0);
        prev_instr = '0;
        prev_pc    = '0;
    endtask

    initial begin
        int dk, endk, plen, sa, ra, wa_k, st;
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.prog_len = '0;
        bus.start    = 1'b0;
        bus.stop     = 1'b0;
        prev_instr   = '0;
        prev_pc      = '0;
        step();
        step();
        check_zero("reset");
        reset = 1'b0;
        step();
        check_zero("post_reset");

        for (int i = 0; i < DEPTH; i++) write_word(AW'(i), 9'($urandom));

        // Directed program: holds 3, 5, 8.
        write_word(AW'(0), 9'b000_001_010);
        write_word(AW'(1), 9'b100_011_000);
        write_word(AW'(2), 9'b111_111_111);
        run_prog(3, -1, -1, -1, '0, '0, -1, dk);
`ifndef SEQ_LOOP_EN
        check("t1_done_at", 32'(dk), 20);
`endif
        // Empty program.
        run_prog(0, -1, -1, -1, '0, '0, -1, dk);
        // Rejected write during the third word's hold, then rerun.
        run_prog(3, -1, -1, 13, AW'(0), 9'h0AA, -1, dk);
        run_prog(3, -1, -1, -1, '0, '0, -1, dk);
        // Stop in the second word's hold; start+stop together.
        run_prog(3, 7, -1, -1, '0, '0, -1, dk);
        start_stop_together();
        // Reset while in ISSUE, then a normal run; clamped length.
        run_prog(3, -1, 0, -1, '0, '0, -1, dk);
        run_prog(3, -1, -1, -1, '0, '0, -1, dk);
        run_prog(2*DEPTH-1, -1, -1, -1, '0, '0, -1, dk);

        for (int r = 0; r < 40; r++) begin
            for (int j = 0; j < int'($urandom_range(0, 3)); j++)
                write_word(AW'($urandom), 9'($urandom));
            plen = int'($urandom_range(0, 2*DEPTH-1));
            endk = (LOOP && clamp_len(plen) > 0) ? 40 : prog_cycles(plen) + 1;
            sa   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, endk - 1)) : -1;
            ra   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, endk - 1)) : -1;
            wa_k = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, endk - 1)) : -1;
            st   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, endk - 2)) : -1;
            run_prog(plen, sa, ra, wa_k, AW'($urandom), 9'($urandom), st, dk);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
